// File: rtl/cnt8_edge_counter.sv
// Up/down event counter stepped by synchronised transitions of the toggle-stage output.
// Provides parallel load, terminal-count pulse, sticky wrap flag and compare match.
module cnt8_edge_counter #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             T_IN,
  input  logic             EN,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic [WIDTH-1:0] CMP_VAL,
  input  logic             CLR_FLAGS,
  output logic [WIDTH-1:0] COUNT,
  output logic             EDGE,
  output logic             TC,
  output logic             OVF,
  output logic             MATCH
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   p_q, p_d;
  logic [WIDTH-1:0]       count_q, count_d;
  logic                   tc_q, tc_d;
  logic                   ovf_q, ovf_d;
  logic                   s_last;
  logic                   edge_det;

  assign s_last = sync_q[SYNC_STAGES-1];

  // Edge strobe is a function of flop outputs only, so it is glitch-free w.r.t. T_IN.
  assign edge_det = (EDGE_MODE != 0) ? (s_last ^ p_q) : (s_last & ~p_q);

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], T_IN};
    p_d     = s_last;
    count_d = count_q;
    tc_d    = 1'b0;
    if (LOAD) begin
      count_d = LOAD_VAL;
    end else if (EN && edge_det) begin
      if (UP) begin
        count_d = count_q + ONE;
        tc_d    = &count_q;
      end else begin
        count_d = count_q - ONE;
        tc_d    = ~|count_q;
      end
    end
    // A wrap in the same cycle as a clear keeps the flag set.
    ovf_d = tc_d | (ovf_q & ~CLR_FLAGS);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q  <= '0;
      p_q     <= 1'b0;
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      p_q     <= p_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign COUNT = count_q;
  assign EDGE  = edge_det;
  assign TC    = tc_q;
  assign OVF   = ovf_q;
  assign MATCH = (count_q == CMP_VAL);

endmodule

// File: tb/tb_cnt8_edge_counter.sv
// Bench for cnt8_edge_counter: a both-edge instance and a rising-only instance share
// stimulus and are checked against an arithmetic event-count model.
module tb_cnt8_edge_counter;

  logic       CLK = 1'b0;
  logic       RST, T_IN, EN, UP, LOAD, CLR_FLAGS;
  logic [7:0] LOAD_VAL, CMP_VAL;

  logic [7:0] count_b, count_r;
  logic       edge_b, edge_r, tc_b, tc_r, ovf_b, ovf_r, match_b, match_r;

  int total = 0;
  int bad   = 0;

  // Reference model: counts per instance, flags, and last level T_IN was driven to.
  logic [7:0] m_cnt_b, m_cnt_r;
  bit         m_tc_b, m_tc_r, m_ovf_b, m_ovf_r, m_tin;

  always #5 CLK = ~CLK;

  cnt8_edge_counter #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_MODE(1)) u_dut_both (
    .CLK(CLK), .RST(RST), .T_IN(T_IN), .EN(EN), .UP(UP), .LOAD(LOAD),
    .LOAD_VAL(LOAD_VAL), .CMP_VAL(CMP_VAL), .CLR_FLAGS(CLR_FLAGS),
    .COUNT(count_b), .EDGE(edge_b), .TC(tc_b), .OVF(ovf_b), .MATCH(match_b)
  );

  cnt8_edge_counter #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_MODE(0)) u_dut_rise (
    .CLK(CLK), .RST(RST), .T_IN(T_IN), .EN(EN), .UP(UP), .LOAD(LOAD),
    .LOAD_VAL(LOAD_VAL), .CMP_VAL(CMP_VAL), .CLR_FLAGS(CLR_FLAGS),
    .COUNT(count_r), .EDGE(edge_r), .TC(tc_r), .OVF(ovf_r), .MATCH(match_r)
  );

  // One counted event: signed arithmetic step, wrap when the result leaves 0..255.
  function automatic void step_model(input logic [7:0] c, input bit up,
                                     output logic [7:0] n, output bit wrapped);
    int v;
    v       = int'(c) + (up ? 1 : -1);
    wrapped = (v < 0) || (v > 255);
    n       = v[7:0];
  endfunction

  task automatic model_reset();
    m_cnt_b = 8'h00; m_cnt_r = 8'h00;
    m_tc_b  = 1'b0;  m_tc_r  = 1'b0;
    m_ovf_b = 1'b0;  m_ovf_r = 1'b0;
    m_tin   = 1'b0;
  endtask

  // Drive T_IN to v at a falling edge and follow the transition through both
  // synchroniser stages to the count update, checking each of the three cycles.
  task automatic drive_tin(input bit v, input bit clr);
    bit         ch, rise, w;
    logic [7:0] n;
    ch        = (v != m_tin);
    rise      = v && !m_tin;
    m_tin     = v;
    T_IN      = v;
    CLR_FLAGS = clr;
    @(negedge CLK);
    if (clr) begin m_ovf_b = 1'b0; m_ovf_r = 1'b0; end
    m_tc_b = 1'b0; m_tc_r = 1'b0;
    total++;
    if ({count_b, count_r} !== {m_cnt_b, m_cnt_r}) begin
      bad++; $display("FAIL e0_count got %h/%h want %h/%h", count_b, count_r, m_cnt_b, m_cnt_r);
    end
    total++;
    if ({edge_b, edge_r, tc_b, tc_r} !== 4'b0000) begin
      bad++; $display("FAIL e0_edge_tc got %b%b%b%b want 0000", edge_b, edge_r, tc_b, tc_r);
    end
    @(negedge CLK);
    if (clr) begin m_ovf_b = 1'b0; m_ovf_r = 1'b0; end
    total++;
    if ({edge_b, edge_r} !== {ch, rise}) begin
      bad++; $display("FAIL e1_edge got %b%b want %b%b", edge_b, edge_r, ch, rise);
    end
    total++;
    if ({count_b, count_r, match_b} !== {m_cnt_b, m_cnt_r, (m_cnt_b == CMP_VAL)}) begin
      bad++; $display("FAIL e1_count_match got %h/%h/%b want %h/%h/%b", count_b, count_r,
                      match_b, m_cnt_b, m_cnt_r, (m_cnt_b == CMP_VAL));
    end
    @(negedge CLK);
    if (EN === 1'b1 && ch) begin step_model(m_cnt_b, UP === 1'b1, n, w); m_cnt_b = n; m_tc_b = w; end
    if (EN === 1'b1 && rise) begin step_model(m_cnt_r, UP === 1'b1, n, w); m_cnt_r = n; m_tc_r = w; end
    m_ovf_b = m_tc_b || (m_ovf_b && !clr);
    m_ovf_r = m_tc_r || (m_ovf_r && !clr);
    total++;
    if ({count_b, count_r} !== {m_cnt_b, m_cnt_r}) begin
      bad++; $display("FAIL e2_count got %h/%h want %h/%h", count_b, count_r, m_cnt_b, m_cnt_r);
    end
    total++;
    if ({tc_b, tc_r, ovf_b, ovf_r} !== {m_tc_b, m_tc_r, m_ovf_b, m_ovf_r}) begin
      bad++; $display("FAIL e2_tc_ovf got %b%b%b%b want %b%b%b%b", tc_b, tc_r, ovf_b, ovf_r,
                      m_tc_b, m_tc_r, m_ovf_b, m_ovf_r);
    end
    total++;
    if ({match_b, match_r, edge_b, edge_r} !==
        {(m_cnt_b == CMP_VAL), (m_cnt_r == CMP_VAL), 2'b00}) begin
      bad++; $display("FAIL e2_match_edge got %b%b%b%b want %b%b00", match_b, match_r, edge_b,
                      edge_r, (m_cnt_b == CMP_VAL), (m_cnt_r == CMP_VAL));
    end
    CLR_FLAGS = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] val);
    LOAD = 1'b1; LOAD_VAL = val;
    @(negedge CLK);
    LOAD = 1'b0;
    m_cnt_b = val; m_cnt_r = val; m_tc_b = 1'b0; m_tc_r = 1'b0;
    total++;
    if ({count_b, count_r, tc_b, tc_r} !== {val, val, 2'b00}) begin
      bad++; $display("FAIL load got %h/%h tc %b%b want %h tc 00", count_b, count_r, tc_b, tc_r, val);
    end
  endtask

  task automatic do_clear();
    CLR_FLAGS = 1'b1;
    @(negedge CLK);
    CLR_FLAGS = 1'b0;
    m_ovf_b = 1'b0; m_ovf_r = 1'b0;
    total++;
    if ({ovf_b, ovf_r} !== 2'b00) begin
      bad++; $display("FAIL clear_ovf got %b%b want 00", ovf_b, ovf_r);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; T_IN = 1'b0; EN = 1'b0; UP = 1'b1; LOAD = 1'b0; CLR_FLAGS = 1'b0;
    LOAD_VAL = 8'h00; CMP_VAL = 8'h00;
    model_reset();
    #2;
    total++;
    if ({count_b, count_r, tc_b, ovf_b, edge_b, edge_r, match_b} !== {16'h0000, 5'b00001}) begin
      bad++; $display("FAIL reset_state got cnt %h/%h tc %b ovf %b edge %b%b match %b",
                      count_b, count_r, tc_b, ovf_b, edge_b, edge_r, match_b);
    end
    CMP_VAL = 8'h05;
    #1;
    total++;
    if (match_b !== 1'b0) begin
      bad++; $display("FAIL reset_match_nonzero got %b want 0", match_b);
    end
    #5;
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_basic_up();
    EN = 1'b1; UP = 1'b1;
    for (int i = 0; i < 8; i++) drive_tin(!m_tin, 1'b0);
    total++;
    if ({count_b, tc_b, ovf_b} !== {8'd8, 2'b00}) begin
      bad++; $display("FAIL basic_up got cnt %h tc %b ovf %b want 08 0 0", count_b, tc_b, ovf_b);
    end
  endtask

  task automatic test_wrap();
    EN = 1'b1; UP = 1'b1;
    do_load(8'hFE);
    drive_tin(!m_tin, 1'b0);
    drive_tin(!m_tin, 1'b0);
    total++;
    if ({count_b, tc_b, ovf_b} !== {8'h00, 2'b11}) begin
      bad++; $display("FAIL wrap_up got cnt %h tc %b ovf %b want 00 1 1", count_b, tc_b, ovf_b);
    end
    @(negedge CLK);
    m_tc_b = 1'b0; m_tc_r = 1'b0;
    total++;
    if ({tc_b, ovf_b} !== 2'b01) begin
      bad++; $display("FAIL wrap_tc_width got tc %b ovf %b want 0 1", tc_b, ovf_b);
    end
    do_clear();
    UP = 1'b0;
    drive_tin(!m_tin, 1'b0);
    total++;
    if ({count_b, tc_b, ovf_b} !== {8'hFF, 2'b11}) begin
      bad++; $display("FAIL wrap_down got cnt %h tc %b ovf %b want ff 1 1", count_b, tc_b, ovf_b);
    end
  endtask

  task automatic test_priority();
    logic [7:0] held_b, held_r;
    do_clear();
    EN = 1'b1; UP = 1'b1;
    do_load(8'hFF);
    m_tin = !m_tin;
    T_IN  = m_tin;
    @(negedge CLK);
    @(negedge CLK);
    total++;
    if (edge_b !== 1'b1) begin
      bad++; $display("FAIL prio_edge_present got %b want 1", edge_b);
    end
    LOAD = 1'b1; LOAD_VAL = 8'h55;
    @(negedge CLK);
    LOAD = 1'b0;
    m_cnt_b = 8'h55; m_cnt_r = 8'h55;
    total++;
    if ({count_b, count_r, tc_b, ovf_b} !== {16'h5555, 2'b00}) begin
      bad++; $display("FAIL prio_load got %h/%h tc %b ovf %b want 55/55 0 0",
                      count_b, count_r, tc_b, ovf_b);
    end
    @(negedge CLK);
    total++;
    if ({count_b, count_r} !== 16'h5555) begin
      bad++; $display("FAIL prio_no_defer got %h/%h want 55/55", count_b, count_r);
    end
    held_b = m_cnt_b; held_r = m_cnt_r;
    EN = 1'b0;
    for (int i = 0; i < 4; i++) drive_tin(!m_tin, 1'b0);
    total++;
    if ({count_b, count_r} !== {held_b, held_r}) begin
      bad++; $display("FAIL en_low_hold got %h/%h want %h/%h", count_b, count_r, held_b, held_r);
    end
    EN = 1'b1;
  endtask

  task automatic test_edge_mode0();
    logic [7:0] start_r;
    EN = 1'b1; UP = 1'b1;
    start_r = m_cnt_r;
    for (int i = 0; i < 8; i++) drive_tin(!m_tin, 1'b0);
    total++;
    if (count_r !== start_r + 8'd4) begin
      bad++; $display("FAIL rise_only_count got %h want %h", count_r, start_r + 8'd4);
    end
    // T_IN already high while reset is released.
    RST = 1'b1; T_IN = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    drive_tin(1'b1, 1'b0);
    total++;
    if ({count_r, count_b} !== 16'h0101) begin
      bad++; $display("FAIL high_at_release got %h/%h want 01/01", count_r, count_b);
    end
  endtask

  task automatic test_compare_flags();
    EN = 1'b1; UP = 1'b1; CMP_VAL = 8'h03;
    do_load(8'h00);
    for (int i = 0; i < 3; i++) drive_tin(!m_tin, 1'b0);
    total++;
    if ({count_b, match_b} !== {8'h03, 1'b1}) begin
      bad++; $display("FAIL match_at_3 got cnt %h match %b want 03 1", count_b, match_b);
    end
    CMP_VAL = 8'h04;
    #1;
    total++;
    if (match_b !== 1'b0) begin
      bad++; $display("FAIL match_comb_change got %b want 0", match_b);
    end
    do_load(8'hFF);
    drive_tin(!m_tin, 1'b1);
    total++;
    if ({tc_b, ovf_b} !== 2'b11) begin
      bad++; $display("FAIL set_beats_clear got tc %b ovf %b want 1 1", tc_b, ovf_b);
    end
  endtask

  task automatic test_async_reset();
    EN = 1'b1; UP = 1'b1;
    do_load(8'hFF);
    drive_tin(!m_tin, 1'b0);
    if (!m_tin) drive_tin(1'b1, 1'b0);
    do_load(8'h10);
    T_IN = 1'b0;
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    total++;
    if ({count_b, count_r, tc_b, ovf_b, ovf_r, edge_b} !== {16'h0000, 4'b0000}) begin
      bad++; $display("FAIL async_reset got cnt %h/%h tc %b ovf %b%b edge %b",
                      count_b, count_r, tc_b, ovf_b, ovf_r, edge_b);
    end
    #1;
    RST = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      total++;
      if ({count_b, count_r, edge_b} !== {16'h0000, 1'b0}) begin
        bad++; $display("FAIL no_stale_incr cyc %0d got %h/%h edge %b want 00/00 0",
                        i, count_b, count_r, edge_b);
      end
    end
  endtask

  task automatic test_random();
    int sel;
    CMP_VAL = 8'($urandom);
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        do_load(($urandom_range(0, 1) == 0) ? 8'($urandom) : (($urandom_range(0, 1) == 0) ? 8'hFF : 8'h00));
      end else if (sel == 1) begin
        do_clear();
      end else begin
        EN = ($urandom_range(0, 4) != 0);
        UP = 1'($urandom);
        drive_tin(1'($urandom), $urandom_range(0, 7) == 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_up();
    test_wrap();
    test_priority();
    test_edge_mode0();
    test_compare_flags();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
